decode_stage_ctrl: RTL and testbench

Registered instruction-decode stage for the pipelined RV32I/RV64I core. It decodes the IF/ID instruction into a control bundle and immediate, and adds LUI/AUIPC, distinct jal/jalr jump types, an ALU-source select and x0-write suppression. It detects load-use hazards against its own ID/EX register, inserts bubbles and honours flush and downstream stall. It owns the ID/EX control/operand-index register between the IF/ID register and the EX stage.

---
 rtl/decode_stage_ctrl_pkg.sv | 40 ++++
 rtl/decode_stage_ctrl_if.sv | 43 ++++
 rtl/decode_stage_ctrl_imm_gen.sv | 28 ++
 rtl/decode_stage_ctrl.sv | 115 +++++++++++
 tb/tb_decode_stage_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/decode_stage_ctrl_pkg.sv
// Shared decode definitions: opcodes, control encodings and the ID/EX control bundle.
package decode_stage_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {ALU_ADD, ALU_BRANCH, ALU_RTYPE, ALU_ITYPE} aluop_e;
  typedef enum logic [1:0] {M2R_MEM, M2R_ALU, M2R_PC4, M2R_IMM}        memtoreg_e;
  typedef enum logic [1:0] {JMP_NONE, JMP_JAL, JMP_JALR, JMP_RSVD}     jump_e;

  typedef struct packed {
    logic      branch;
    logic      regwrite;
    logic      memread;
    logic      memwrite;
    logic      alusrc;
    aluop_e    aluop;
    memtoreg_e memtoreg;
    jump_e     jump;
    logic      illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/decode_stage_ctrl_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the decode stage.
interface decode_stage_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             instr_valid_i;
  logic [31:0]      instr_i;
  logic             flush_i;
  logic             ex_stall_i;
  logic             stall_o;
  logic             ex_valid_o;
  logic             ex_branch_o;
  logic             ex_regwrite_o;
  logic             ex_memread_o;
  logic             ex_memwrite_o;
  logic             ex_alusrc_o;
  logic [1:0]       ex_aluop_o;
  logic [1:0]       ex_memtoreg_o;
  logic [1:0]       ex_jump_o;
  logic [4:0]       ex_rs1_o;
  logic [4:0]       ex_rs2_o;
  logic [4:0]       ex_rd_o;
  logic [3:0]       ex_funct_o;
  logic [XLEN-1:0]  ex_imm_o;
  logic             ex_illegal_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output instr_i, instr_valid_i, flush_i, ex_stall_i,
    input  stall_o, ex_valid_o, ex_branch_o, ex_regwrite_o, ex_memread_o,
           ex_memwrite_o, ex_alusrc_o, ex_aluop_o, ex_memtoreg_o, ex_jump_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o, ex_imm_o, ex_illegal_o,
           bubble_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i, ex_stall_i,
    output stall_o, ex_valid_o, ex_branch_o, ex_regwrite_o, ex_memread_o,
           ex_memwrite_o, ex_alusrc_o, ex_aluop_o, ex_memtoreg_o, ex_jump_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o, ex_imm_o, ex_illegal_o,
           bubble_cnt_o
  );
endinterface

// File: rtl/decode_stage_ctrl_imm_gen.sv
// Immediate extraction by opcode format, sign-extended from bit 31 to XLEN.
module decode_stage_ctrl_imm_gen
  import decode_stage_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr_i[6:0])
      OP_IALU, OP_LOAD, OP_JALR: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      OP_STORE:                  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OP_BRANCH:                 imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                          instr_i[30:25], instr_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:          imm32 = {instr_i[31:12], 12'b0};
      OP_JAL:                    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                          instr_i[20], instr_i[30:21], 1'b0};
      default:                   imm32 = '0;
    endcase
  end

  // Every format already carries bit 31 in the top bit, so one signed widen covers RV64.
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage_ctrl.sv
// ID stage: decodes IF/ID into the ID/EX register, with load-use bubbles, flush and EX stall.
module decode_stage_ctrl
  import decode_stage_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  decode_stage_ctrl_if.slave  bus
);
  logic [6:0]       opcode;
  logic [4:0]       rs1, rs2, rd;
  ctrl_t            dec;
  logic [XLEN-1:0]  imm;
  logic             hazard, load_en, bubble;

  logic             ex_valid_q, ex_valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]       funct_q, funct_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign opcode = bus.instr_i[6:0];
  assign rd     = bus.instr_i[11:7];
  assign rs1    = bus.instr_i[19:15];
  assign rs2    = bus.instr_i[24:20];

  decode_stage_ctrl_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (bus.instr_i),
    .imm_o   (imm)
  );

  always_comb begin
    dec = CTRL_NOP;
    case (opcode)
      OP_R:      begin dec.regwrite = 1'b1; dec.aluop = ALU_RTYPE; dec.memtoreg = M2R_ALU; end
      OP_IALU:   begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_ITYPE;
                       dec.memtoreg = M2R_ALU; end
      OP_LOAD:   begin dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alusrc = 1'b1;
                       dec.memtoreg = M2R_MEM; end
      OP_STORE:  begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      OP_BRANCH: begin dec.branch = 1'b1; dec.aluop = ALU_BRANCH; end
      OP_JAL:    begin dec.regwrite = 1'b1; dec.jump = JMP_JAL; dec.memtoreg = M2R_PC4; end
      OP_JALR:   begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jump = JMP_JALR;
                       dec.memtoreg = M2R_PC4; end
      OP_LUI:    begin dec.regwrite = 1'b1; dec.memtoreg = M2R_IMM; end
      OP_AUIPC:  begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_ADD;
                       dec.memtoreg = M2R_ALU; end
      default:   dec.illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec.regwrite = 1'b0;
  end

  // Only a load sitting in ID/EX can produce a value too late for forwarding.
  assign hazard = ex_valid_q & ctrl_q.memread & (rd_q != 5'd0) & bus.instr_valid_i &
                  ((uses_rs1(opcode) & (rs1 == rd_q)) | (uses_rs2(opcode) & (rs2 == rd_q)));

  assign load_en     = bus.flush_i | ~bus.ex_stall_i;
  assign bubble      = bus.flush_i | hazard | ~bus.instr_valid_i;
  assign bus.stall_o = rst_i & ~bus.flush_i & (bus.ex_stall_i | hazard);

  always_comb begin
    ex_valid_d = bubble ? 1'b0      : 1'b1;
    ctrl_d     = bubble ? CTRL_NOP  : dec;
    rs1_d      = bubble ? 5'd0      : rs1;
    rs2_d      = bubble ? 5'd0      : rs2;
    rd_d       = bubble ? 5'd0      : rd;
    funct_d    = bubble ? 4'd0      : {bus.instr_i[30], bus.instr_i[14:12]};
    imm_d      = bubble ? '0        : imm;
    cnt_d      = cnt_q;
    if (hazard && !bus.flush_i && !bus.ex_stall_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      imm_q      <= '0;
      cnt_q      <= '0;
    end else if (load_en) begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
      imm_q      <= imm_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid_o    = ex_valid_q;
  assign bus.ex_branch_o   = ctrl_q.branch;
  assign bus.ex_regwrite_o = ctrl_q.regwrite;
  assign bus.ex_memread_o  = ctrl_q.memread;
  assign bus.ex_memwrite_o = ctrl_q.memwrite;
  assign bus.ex_alusrc_o   = ctrl_q.alusrc;
  assign bus.ex_aluop_o    = ctrl_q.aluop;
  assign bus.ex_memtoreg_o = ctrl_q.memtoreg;
  assign bus.ex_jump_o     = ctrl_q.jump;
  assign bus.ex_illegal_o  = ctrl_q.illegal;
  assign bus.ex_rs1_o      = rs1_q;
  assign bus.ex_rs2_o      = rs2_q;
  assign bus.ex_rd_o       = rd_q;
  assign bus.ex_funct_o    = funct_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench: decode table on RV32 and RV64/2-bit-counter instances, then hazard/flush/stall/reset sequences.
module tb_decode_stage_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  decode_stage_ctrl_if #(.XLEN(32), .CNT_W(16)) b32 ();
  decode_stage_ctrl_if #(.XLEN(64), .CNT_W(2))  b64 ();

  decode_stage_ctrl #(.XLEN(32), .CNT_W(16)) dut32 (.clk_i(clk_i), .rst_i(rst_i), .bus(b32));
  decode_stage_ctrl #(.XLEN(64), .CNT_W(2))  dut64 (.clk_i(clk_i), .rst_i(rst_i), .bus(b64));

  logic [11:0] ctrl32, ctrl64;
  assign ctrl32 = {b32.ex_branch_o, b32.ex_regwrite_o, b32.ex_memread_o, b32.ex_memwrite_o,
                   b32.ex_alusrc_o, b32.ex_aluop_o, b32.ex_memtoreg_o, b32.ex_jump_o, b32.ex_illegal_o};
  assign ctrl64 = {b64.ex_branch_o, b64.ex_regwrite_o, b64.ex_memread_o, b64.ex_memwrite_o,
                   b64.ex_alusrc_o, b64.ex_aluop_o, b64.ex_memtoreg_o, b64.ex_jump_o, b64.ex_illegal_o};

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        ev;
    logic [11:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  function automatic logic [11:0] mk(input logic br, rw, mr, mw, as,
                                     input logic [1:0] aop, m2r, j, input logic ill);
    return {br, rw, mr, mw, as, aop, m2r, j, ill};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic vld, input logic fl, input logic st);
    b32.instr_i = instr; b32.instr_valid_i = vld; b32.flush_i = fl; b32.ex_stall_i = st;
    b64.instr_i = instr; b64.instr_valid_i = vld; b64.flush_i = fl; b64.ex_stall_i = st;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, {63'd0, b32.ex_valid_o}, 64'd0);
    chk({tag, " ctrl"},  {52'd0, ctrl32}, 64'd0);
    chk({tag, " idx"},   {49'd0, b32.ex_rs1_o, b32.ex_rs2_o, b32.ex_rd_o}, 64'd0);
    chk({tag, " funct"}, {60'd0, b32.ex_funct_o}, 64'd0);
    chk({tag, " imm"},   {32'd0, b32.ex_imm_o}, 64'd0);
    chk({tag, " cnt"},   {48'd0, b32.bubble_cnt_o}, 64'd0);
    chk({tag, " stall"}, {63'd0, b32.stall_o}, 64'd0);
    chk({tag, " valid64"}, {63'd0, b64.ex_valid_o}, 64'd0);
    chk({tag, " imm64"},   b64.ex_imm_o, 64'd0);
    chk({tag, " cnt64"},   {62'd0, b64.bubble_cnt_o}, 64'd0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_USE  = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] I_LUI  = 32'h123453B7; // lui x7,0x12345

  vec_t vt[12];

  initial begin
    vt[0]  = '{I_ADD,        1, 1, mk(0,1,0,0,0,2'b10,2'b01,2'b00,0), 5'd3,  32'h0};
    vt[1]  = '{I_LUI,        1, 1, mk(0,1,0,0,0,2'b00,2'b11,2'b00,0), 5'd7,  32'h12345000};
    vt[2]  = '{32'hFFDFF0EF, 1, 1, mk(0,1,0,0,0,2'b00,2'b10,2'b01,0), 5'd1,  32'hFFFFFFFC};
    vt[3]  = '{32'h00100013, 1, 1, mk(0,0,0,0,1,2'b11,2'b01,2'b00,0), 5'd0,  32'h1};
    vt[4]  = '{32'h0000007F, 1, 1, mk(0,0,0,0,0,2'b00,2'b00,2'b00,1), 5'd0,  32'h0};
    vt[5]  = '{32'h0020A423, 1, 1, mk(0,0,0,1,1,2'b00,2'b00,2'b00,0), 5'd8,  32'h8};
    vt[6]  = '{32'hFE208CE3, 1, 1, mk(1,0,0,0,0,2'b01,2'b00,2'b00,0), 5'd25, 32'hFFFFFFF8};
    vt[7]  = '{32'h004280E7, 1, 1, mk(0,1,0,0,1,2'b00,2'b10,2'b10,0), 5'd1,  32'h4};
    vt[8]  = '{32'h00001217, 1, 1, mk(0,1,0,0,1,2'b00,2'b01,2'b00,0), 5'd4,  32'h1000};
    vt[9]  = '{32'hFFF00493, 1, 1, mk(0,1,0,0,1,2'b11,2'b01,2'b00,0), 5'd9,  32'hFFFFFFFF};
    vt[10] = '{I_ADD,        0, 0, 12'd0,                              5'd0,  32'h0};
    vt[11] = '{I_LW,         1, 1, mk(0,1,1,0,1,2'b00,2'b00,2'b00,0), 5'd5,  32'h0};

    drive(32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    chk_zero("reset");
    step();
    rst_i = 1'b1;
    step();

    foreach (vt[i]) begin
      drive(vt[i].instr, vt[i].vld, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d valid", i), {63'd0, b32.ex_valid_o}, {63'd0, vt[i].ev});
      chk($sformatf("vec%0d ctrl", i),  {52'd0, ctrl32}, {52'd0, vt[i].ctrl});
      chk($sformatf("vec%0d rd", i),    {59'd0, b32.ex_rd_o}, {59'd0, vt[i].rd});
      chk($sformatf("vec%0d imm", i),   {32'd0, b32.ex_imm_o}, {32'd0, vt[i].imm});
      chk($sformatf("vec%0d imm64", i), b64.ex_imm_o, {{32{vt[i].imm[31]}}, vt[i].imm});
      chk($sformatf("vec%0d ctrl64", i), {52'd0, ctrl64}, {52'd0, vt[i].ctrl});
    end

    // load-use: one stall cycle, one bubble, then the dependent add issues
    drive(32'h0, 1'b0, 1'b0, 1'b0); step();
    drive(I_LW, 1'b1, 1'b0, 1'b0);  step();
    drive(I_USE, 1'b1, 1'b0, 1'b0); #1;
    chk("lu stall", {63'd0, b32.stall_o}, 64'd1);
    step();
    chk("lu bubble valid", {63'd0, b32.ex_valid_o}, 64'd0);
    chk("lu bubble ctrl",  {52'd0, ctrl32}, 64'd0);
    chk("lu cnt",          {48'd0, b32.bubble_cnt_o}, 64'd1);
    chk("lu stall clear",  {63'd0, b32.stall_o}, 64'd0);
    step();
    chk("lu issue valid", {63'd0, b32.ex_valid_o}, 64'd1);
    chk("lu issue idx",   {49'd0, b32.ex_rs1_o, b32.ex_rs2_o, b32.ex_rd_o}, {49'd0, 5'd5, 5'd1, 5'd6});
    chk("lu issue ctrl",  {52'd0, ctrl32}, {52'd0, mk(0,1,0,0,0,2'b10,2'b01,2'b00,0)});
    chk("lu cnt hold",    {48'd0, b32.bubble_cnt_o}, 64'd1);

    // funct field of sub
    drive(32'h402081B3, 1'b1, 1'b0, 1'b0); step();
    chk("sub funct", {60'd0, b32.ex_funct_o}, 64'd8);

    // flush in the hazard cycle
    drive(I_LW, 1'b1, 1'b0, 1'b0);  step();
    drive(I_USE, 1'b1, 1'b1, 1'b0); #1;
    chk("flush hz stall", {63'd0, b32.stall_o}, 64'd0);
    step();
    chk("flush hz valid", {63'd0, b32.ex_valid_o}, 64'd0);
    chk("flush hz cnt",   {48'd0, b32.bubble_cnt_o}, 64'd1);
    drive(I_USE, 1'b1, 1'b0, 1'b0); #1;
    chk("post flush stall", {63'd0, b32.stall_o}, 64'd0);
    step();
    chk("post flush rd", {59'd0, b32.ex_rd_o}, 64'd6);

    // EX stall holds ID/EX for three cycles
    drive(I_LUI, 1'b1, 1'b0, 1'b0); step();
    drive(I_ADD, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d stall", k), {63'd0, b32.stall_o}, 64'd1);
      step();
      chk($sformatf("hold%0d valid", k), {63'd0, b32.ex_valid_o}, 64'd1);
      chk($sformatf("hold%0d rd", k),    {59'd0, b32.ex_rd_o}, 64'd7);
      chk($sformatf("hold%0d imm", k),   {32'd0, b32.ex_imm_o}, 64'h12345000);
      chk($sformatf("hold%0d ctrl", k),  {52'd0, ctrl32}, {52'd0, mk(0,1,0,0,0,2'b00,2'b11,2'b00,0)});
    end
    drive(I_ADD, 1'b1, 1'b0, 1'b0); step();
    chk("release rd", {59'd0, b32.ex_rd_o}, 64'd3);

    // flush beats EX stall
    drive(I_ADD, 1'b1, 1'b1, 1'b1); #1;
    chk("fl+st stall", {63'd0, b32.stall_o}, 64'd0);
    step();
    chk("fl+st valid", {63'd0, b32.ex_valid_o}, 64'd0);

    // five more hazards: 16-bit counter reaches 6, 2-bit counter sticks at 3
    for (int k = 0; k < 5; k++) begin
      drive(I_LW, 1'b1, 1'b0, 1'b0);  step();
      drive(I_USE, 1'b1, 1'b0, 1'b0); step(); step();
    end
    chk("sat cnt16", {48'd0, b32.bubble_cnt_o}, 64'd6);
    chk("sat cnt2",  {62'd0, b64.bubble_cnt_o}, 64'd3);
    chk("sat issue valid", {63'd0, b32.ex_valid_o}, 64'd1);

    // asynchronous reset between edges
    drive(I_ADD, 1'b1, 1'b0, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_zero("async rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
